pipe_skid_reg: RTL and testbench

- Two-entry skid-buffered pipeline register with valid/ready handshakes on both sides.
- Drop-in replacement for a plain enabled pipeline register wherever the downstream stage can stall, for example the memory stage waiting on a slow data port.
- Lets the upstream stage run against a registered ready, so there is no combinational ready path back through the pipeline.
- Supports a full-throughput stream at one transfer per cycle, and a synchronous flush for branch/exception squash.

---
 rtl/pipe_skid_reg.sv | 86 ++++++++
 tb/tb_pipe_skid_reg.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register: registered in_ready/out_valid,
// strict FIFO order, full throughput, synchronous flush.
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // state | meaning
    // EMPTY | no entries held
    // BUSY  | main holds the head entry
    // FULL  | main holds the head, skid holds the next entry
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                case ({in_fire, out_fire})
                    2'b11: main_d = in_data;
                    2'b10: begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end
                    2'b01:   state_d = EMPTY;
                    default: state_d = BUSY;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            // the unused encoding falls back to EMPTY
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a queue model of accepted payloads is
// compared against the DUT handshakes and output data every cycle.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             stalled_prev = 1'b0;
    logic [WIDTH-1:0] data_prev = '0;

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs against the model mid-cycle, then advance the model
    // with this cycle's handshakes and step to just after the next edge.
    task automatic cycle();
        int  cnt;
        logic mdl_in_fire, mdl_out_fire;
        @(negedge clk);
        cnt = exp_q.size();
        check("out_valid", {31'd0, out_valid}, {31'd0, cnt != 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, cnt != 2});
        if (cnt != 0) begin
            check("out_data", out_data, exp_q[0]);
        end
        if (stalled_prev) begin
            check("hold_data", out_data, data_prev);
        end
        mdl_in_fire  = in_valid && (cnt != 2);
        mdl_out_fire = (cnt != 0) && out_ready;
        stalled_prev = (cnt != 0) && !out_ready && !reset && !flush;
        data_prev    = out_data;
        if (mdl_out_fire) begin
            void'(exp_q.pop_front());
        end
        if (reset || flush) begin
            exp_q.delete();
        end else if (mdl_in_fire) begin
            exp_q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        cycle();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // reset held with a live upstream offer
        for (int i = 0; i < 2; i++) begin
            check("rst_out_data", out_data, 32'h0);
            cycle();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_release_data", out_data, 32'h0);
        check("rst_release_valid", {31'd0, out_valid}, 32'h0);
        cycle();

        // streaming with no backpressure
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, WIDTH'(i), 1'b1);
        end
        drive(1'b0, '0, 1'b1);
        check("stream_drained", {31'd0, out_valid}, 32'h0);

        // stall fill: A loaded, then B into skid while stalled, C held
        drive(1'b1, 32'hA, 1'b1);
        drive(1'b1, 32'hB, 1'b0);
        check("fill_in_ready", {31'd0, in_ready}, 32'h0);
        check("fill_head", out_data, 32'hA);
        drive(1'b1, 32'hC, 1'b0);
        drive(1'b1, 32'hC, 1'b0);
        check("fill_still_a", out_data, 32'hA);

        // drain A, B, C
        drive(1'b1, 32'hC, 1'b1);
        check("drain_b", out_data, 32'hB);
        check("drain_in_ready", {31'd0, in_ready}, 32'h1);
        drive(1'b1, 32'hC, 1'b1);
        check("drain_c", out_data, 32'hC);
        drive(1'b0, '0, 1'b1);
        check("drain_empty", {31'd0, out_valid}, 32'h0);

        // flush while FULL with a live offer of F
        drive(1'b1, 32'hA, 1'b0);
        drive(1'b1, 32'hB, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'hF, 1'b0);
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'h0);
        check("flush_in_ready", {31'd0, in_ready}, 32'h1);
        drive(1'b0, '0, 1'b1);
        check("flush_no_f", {31'd0, out_valid}, 32'h0);

        // mid-stream reset while FULL
        drive(1'b1, 32'h11, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        reset = 1'b0;
        check("midrst_data", out_data, 32'h0);
        drive(1'b0, '0, 1'b1);

        // random traffic with backpressure and rare flushes
        for (int i = 0; i < 1000; i++) begin
            flush = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
        end
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
        end
        check("final_empty", {31'd0, out_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
